fc_layer_seq: RTL and testbench

Sequential fully-connected layer that sits directly downstream of the convolutional front end. It consumes the flattened pooled feature map (3×3×32 = 288 words), computes OUT_NODES dot products plus bias with a single time-multiplexed MAC, and presents a registered output vector with a one-cycle `done` pulse. Its cost is one multiplier instead of IN_NODES×OUT_NODES multipliers, paid for with (IN_NODES+2) cycles per output node.

---
 rtl/fc_pkg.sv | 26 ++
 rtl/fc_mac_unit.sv | 66 ++++++
 rtl/fc_layer_seq.sv | 126 ++++++++++++
 tb/tb_fc_layer_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and helpers for the sequential fully-connected layer:
// FSM state encoding, accumulator width and output saturation bounds.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MAC   = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } fc_state_t;

  // Full-precision products plus enough headroom for in_n of them.
  function automatic int ACC_W(input int dw, input int in_n);
    return 2 * dw + $clog2(in_n);
  endfunction

  function automatic longint SAT_MAX(input int dw);
    return (longint'(1) <<< (dw - 1)) - longint'(1);
  endfunction

  function automatic longint SAT_MIN(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Single signed multiply-accumulate with bias preload, followed by the
// shift/saturate output stage. Defining FC_RELU_EN clamps negative results to 0.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IN_NODES   = 288
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_bias,
  input  logic [DATA_WIDTH-1:0] i_x,
  input  logic [DATA_WIDTH-1:0] i_w,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int AW = ACC_W(DATA_WIDTH, IN_NODES);
  localparam logic signed [AW-1:0] L_SAT_MAX = AW'(SAT_MAX(DATA_WIDTH));
  localparam logic signed [AW-1:0] L_SAT_MIN = AW'(SAT_MIN(DATA_WIDTH));

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [AW-1:0]           w_prod_ext;
  logic signed [AW-1:0]           w_bias_ext;
  logic signed [AW-1:0]           w_shift;
  logic signed [AW-1:0]           r_acc;
  logic        [DATA_WIDTH-1:0]   w_sat;

  assign w_prod     = $signed(i_x) * $signed(i_w);
  assign w_prod_ext = AW'(w_prod);
  // Bias is aligned to the Q(2F) scale of the products before accumulation.
  assign w_bias_ext = AW'($signed(i_bias)) <<< FRAC_BITS;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= w_bias_ext;
    end else if (i_en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign w_shift = r_acc >>> FRAC_BITS;

  always_comb begin
    w_sat = w_shift[DATA_WIDTH-1:0];
    if (w_shift > L_SAT_MAX) begin
      w_sat = L_SAT_MAX[DATA_WIDTH-1:0];
    end else if (w_shift < L_SAT_MIN) begin
      w_sat = L_SAT_MIN[DATA_WIDTH-1:0];
    end
  end

`ifdef FC_RELU_EN
  assign o_result = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign o_result = w_sat;
`endif

endmodule

// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one MAC time-multiplexed over all
// OUT_NODES x IN_NODES terms; (IN_NODES+2) cycles per node. Optional FC_RELU_EN.
module fc_layer_seq
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IN_NODES   = 288,
  parameter int OUT_NODES  = 10
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [IN_NODES*DATA_WIDTH-1:0]           fc_input,
  input  logic [IN_NODES*OUT_NODES*DATA_WIDTH-1:0] weights,
  input  logic [OUT_NODES*DATA_WIDTH-1:0]          biases,
  output logic [OUT_NODES*DATA_WIDTH-1:0]          fc_output,
  output logic                                 busy,
  output logic                                 done
);

  localparam int JW = (OUT_NODES > 1) ? $clog2(OUT_NODES) : 1;
  localparam int IW = (IN_NODES > 1) ? $clog2(IN_NODES) : 1;

  fc_state_t             r_state;
  fc_state_t             w_state_next;
  logic [JW-1:0]         r_j;
  logic [IW-1:0]         r_i;
  logic                  r_busy;
  logic                  r_done;
  logic                  w_last_i;
  logic                  w_last_j;
  logic [31:0]           w_x_base;
  logic [31:0]           w_w_base;
  logic [31:0]           w_b_base;
  logic [DATA_WIDTH-1:0] w_x;
  logic [DATA_WIDTH-1:0] w_w;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_start_run;

  assign w_last_i    = (r_i == IW'(IN_NODES - 1));
  assign w_last_j    = (r_j == JW'(OUT_NODES - 1));
  assign w_start_run = (r_state == ST_IDLE) && start;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_MAC;
      ST_MAC:   if (w_last_i) w_state_next = ST_WRITE;
      ST_WRITE: w_state_next = w_last_j ? ST_DONE : ST_LOAD;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_j     <= '0;
      r_i     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Flags follow the next state so they line up with the state register.
      r_busy  <= (w_state_next == ST_LOAD) || (w_state_next == ST_MAC) ||
                 (w_state_next == ST_WRITE);
      r_done  <= (w_state_next == ST_DONE);
      if (w_start_run) begin
        r_j <= '0;
        r_i <= '0;
      end else if (r_state == ST_LOAD) begin
        r_i <= '0;
      end else if (r_state == ST_MAC) begin
        r_i <= w_last_i ? '0 : r_i + 1'b1;
      end else if (r_state == ST_WRITE && !w_last_j) begin
        r_j <= r_j + 1'b1;
      end
    end
  end

  // Operands are taken straight from the held flat buses each cycle.
  assign w_x_base = 32'(r_i) * DATA_WIDTH;
  assign w_w_base = (32'(r_j) * IN_NODES + 32'(r_i)) * DATA_WIDTH;
  assign w_b_base = 32'(r_j) * DATA_WIDTH;
  assign w_x      = fc_input[w_x_base +: DATA_WIDTH];
  assign w_w      = weights[w_w_base +: DATA_WIDTH];
  assign w_b      = biases[w_b_base +: DATA_WIDTH];

  fc_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .IN_NODES  (IN_NODES)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start_run),
    .i_load  (r_state == ST_LOAD),
    .i_en    (r_state == ST_MAC),
    .i_bias  (w_b),
    .i_x     (w_x),
    .i_w     (w_w),
    .o_result(w_result)
  );

  genvar gi;
  generate
    for (gi = 0; gi < OUT_NODES; gi++) begin : g_out
      logic [DATA_WIDTH-1:0] r_y;
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_y <= '0;
        end else if (r_state == ST_WRITE && r_j == JW'(gi)) begin
          r_y <= w_result;
        end
      end
      assign fc_output[gi*DATA_WIDTH +: DATA_WIDTH] = r_y;
    end
  endgenerate

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Scoreboard bench for fc_layer_seq with IN_NODES=4, OUT_NODES=2.
// Build with +define+FC_RELU_EN to check the ReLU variant.
module tb_fc_layer_seq;

  localparam int DW   = 16;
  localparam int FRAC = 8;
  localparam int IN   = 4;
  localparam int OUT  = 2;
  localparam int NCYC = OUT * (IN + 2);

  typedef logic [OUT*DW-1:0]    yvec_t;
  typedef logic [IN*DW-1:0]     xvec_t;
  typedef logic [IN*OUT*DW-1:0] wvec_t;

`ifdef FC_RELU_EN
  localparam logic [15:0] Y1_BASIC = 16'h0000;
  localparam logic [15:0] Y_NEGSAT = 16'h0000;
  localparam logic [15:0] Y1_B2B   = 16'h0000;
`else
  localparam logic [15:0] Y1_BASIC = 16'hFF40;
  localparam logic [15:0] Y_NEGSAT = 16'h8000;
  localparam logic [15:0] Y1_B2B   = 16'hFE00;
`endif

  logic  clk = 1'b0;
  logic  reset;
  logic  start;
  xvec_t fc_input;
  wvec_t weights;
  yvec_t biases;
  yvec_t fc_output;
  logic  busy;
  logic  done;

  int    n_checks = 0;
  int    n_errors = 0;
  yvec_t exp_q[$];
  yvec_t sb_exp;

  always #5 clk = ~clk;

  fc_layer_seq #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (FRAC),
    .IN_NODES  (IN),
    .OUT_NODES (OUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .fc_input (fc_input),
    .weights  (weights),
    .biases   (biases),
    .fc_output(fc_output),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: Q8 fixed point computed with 64-bit integer arithmetic.
  function automatic yvec_t model(input xvec_t x, input wvec_t w, input yvec_t b);
    yvec_t y;
    for (int j = 0; j < OUT; j++) begin
      longint acc;
      longint r;
      acc = longint'($signed(b[j*DW +: DW])) * 256;
      for (int i = 0; i < IN; i++)
        acc += longint'($signed(x[i*DW +: DW])) * longint'($signed(w[(j*IN+i)*DW +: DW]));
      r = acc >>> FRAC;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`ifdef FC_RELU_EN
      if (r < 0) r = 0;
`endif
      y[j*DW +: DW] = r[15:0];
    end
    return y;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued run.
  always begin
    @(posedge clk);
    #1;
    if (done) begin
      if (exp_q.size() == 0) begin
        chk_eq("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        sb_exp = exp_q.pop_front();
        for (int j = 0; j < OUT; j++)
          chk_eq($sformatf("y%0d", j), 64'(fc_output[j*DW +: DW]), 64'(sb_exp[j*DW +: DW]));
        $display("run done: y0=%h y1=%h", fc_output[15:0], fc_output[31:16]);
      end
    end
  end

  // One run: start at edge 0, optional extra start pulses / reset at edge k.
  task automatic run(input xvec_t x, input wvec_t w, input yvec_t b, input yvec_t exp,
                     input int s1, input int s2, input int rst_at);
    fc_input = x;
    weights  = w;
    biases   = b;
    start    = 1'b1;
    if (rst_at < 0) exp_q.push_back(exp);
    tick();
    start = 1'b0;
    chk_eq("busy_e0", 64'(busy), 64'd1);
    for (int k = 1; k <= NCYC + 1; k++) begin
      start = (k == s1) || (k == s2);
      reset = (k == rst_at) ? 1'b0 : 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b1;
      if (k == rst_at) begin
        chk_eq("rst_out", 64'(fc_output), 64'd0);
        chk_eq("rst_busy", 64'(busy), 64'd0);
        chk_eq("rst_done", 64'(done), 64'd0);
        return;
      end
      chk_eq($sformatf("busy_e%0d", k), 64'(busy), 64'(k < NCYC));
      chk_eq($sformatf("done_e%0d", k), 64'(done), 64'(k == NCYC));
      if (k == IN + 2) chk_eq("y0_early", 64'(fc_output[DW-1:0]), 64'(exp[DW-1:0]));
    end
  endtask

  xvec_t x_basic, x_sat, x_r;
  wvec_t w_basic, w_pos, w_neg, w_r;
  yvec_t b_basic, b_r, y_basic;

  initial begin
    x_basic = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
    w_basic = {{4{16'h0080}}, {4{16'h0100}}};
    b_basic = {16'hFE00, 16'h0080};
    y_basic = {Y1_BASIC, 16'h0300};
    x_sat   = {4{16'h7FFF}};
    w_pos   = {8{16'h7FFF}};
    w_neg   = {8{16'h8000}};

    reset    = 1'b0;
    start    = 1'b0;
    fc_input = '0;
    weights  = '0;
    biases   = '0;
    repeat (3) tick();
    chk_eq("reset_out", 64'(fc_output), 64'd0);
    chk_eq("reset_busy", 64'(busy), 64'd0);
    chk_eq("reset_done", 64'(done), 64'd0);
    reset = 1'b1;
    tick();

    $display("basic run");
    run(x_basic, w_basic, b_basic, y_basic, -1, -1, -1);
    $display("start while busy");
    run(x_basic, w_basic, b_basic, y_basic, 3, NCYC, -1);
    $display("reset mid-run");
    run(x_basic, w_basic, b_basic, y_basic, -1, -1, 8);
    run(x_basic, w_basic, b_basic, y_basic, -1, -1, -1);
    $display("back-to-back, x=0");
    run('0, w_basic, b_basic, {Y1_B2B, 16'h0080}, -1, -1, -1);
    $display("positive saturation");
    run(x_sat, w_pos, '0, {2{16'h7FFF}}, -1, -1, -1);
    $display("negative saturation");
    run(x_sat, w_neg, '0, {2{Y_NEGSAT}}, -1, -1, -1);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < IN; i++) x_r[i*DW +: DW] = DW'($urandom);
      for (int i = 0; i < IN * OUT; i++) w_r[i*DW +: DW] = DW'($urandom_range(0, 1023)) - 16'd512;
      for (int i = 0; i < OUT; i++) b_r[i*DW +: DW] = DW'($urandom);
      $display("random run %0d", t);
      run(x_r, w_r, b_r, model(x_r, w_r, b_r), -1, -1, -1);
    end

    repeat (4) tick();
    chk_eq("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
